// File: rtl/dram_port_arbiter_pkg.sv
// Shared types and constants for the two-port DRAM arbiter.
package dram_port_arbiter_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } arb_state_e;

  // Default WAIT budget before a transaction is forced to complete.
  localparam int unsigned DRAM_ARB_TIMEOUT_DEFAULT = 1023;

  // Read data handed back when the DRAM never acknowledges.
  localparam logic [31:0] DRAM_ARB_TIMEOUT_DATA = 32'hDEAD_BEEF;

  // The port that is not `port` in a two-way arbiter.
  function automatic logic other_port(input logic port);
    return ~port;
  endfunction

endpackage

// File: rtl/dram_port_arbiter_rr_picker.sv
// Two-way round-robin select: combinational pick plus a registered priority pointer.
module dram_port_arbiter_rr_picker
  import dram_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       sync_reset,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       served,
  output logic       pick,
  output logic       pick_valid
);

  logic pointer_q;
  logic pointer_d;

  // Pointer port wins a tie; a lone requester wins regardless of the pointer.
  always_comb begin
    pick_valid = |req;
    if (req[pointer_q]) begin
      pick = pointer_q;
    end else begin
      pick = other_port(pointer_q);
    end
    pointer_d = advance ? other_port(served) : pointer_q;
  end

  // Priority pointer register, cleared to port 0 by either reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pointer_q <= 1'b0;
    end else if (sync_reset) begin
      pointer_q <= 1'b0;
    end else begin
      pointer_q <= pointer_d;
    end
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares one external DRAM port between the MCU memory controller (port 0) and a
// DMA/debug bulk-load master (port 1). One transaction in flight, round-robin grant,
// ack timeout with a sticky error flag.
module dram_port_arbiter
  import dram_port_arbiter_pkg::*;
#(
  parameter int unsigned          ADDR_BITS      = 24,
  parameter int unsigned          DATA_BITS      = 32,
  parameter int unsigned          TIMEOUT_CYCLES = DRAM_ARB_TIMEOUT_DEFAULT,
  parameter logic [DATA_BITS-1:0] TIMEOUT_DATA   = DATA_BITS'(DRAM_ARB_TIMEOUT_DATA)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sync_reset,

  input  logic                   req0_read_en,
  input  logic                   req0_write_en,
  input  logic [ADDR_BITS-1:0]   req0_addr,
  input  logic [DATA_BITS/8-1:0] req0_byte_enable,
  input  logic [DATA_BITS-1:0]   req0_write_data,
  output logic                   req0_ack,
  output logic [DATA_BITS-1:0]   req0_read_data,

  input  logic                   req1_read_en,
  input  logic                   req1_write_en,
  input  logic [ADDR_BITS-1:0]   req1_addr,
  input  logic [DATA_BITS/8-1:0] req1_byte_enable,
  input  logic [DATA_BITS-1:0]   req1_write_data,
  output logic                   req1_ack,
  output logic [DATA_BITS-1:0]   req1_read_data,

  output logic                   dram_mem_read_en,
  output logic                   dram_mem_write_en,
  output logic [ADDR_BITS-1:0]   dram_mem_addr,
  output logic [DATA_BITS/8-1:0] dram_mem_byte_enable,
  output logic [DATA_BITS-1:0]   dram_mem_write_data,
  input  logic                   dram_ack,
  input  logic [DATA_BITS-1:0]   dram_mem_read_data,

  output logic                   grant,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int unsigned BE_BITS  = DATA_BITS / 8;
  localparam int unsigned CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_BITS-1:0] CNT_LIMIT = CNT_BITS'(TIMEOUT_CYCLES);

  arb_state_e           state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 write_q, write_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [BE_BITS-1:0]   be_q, be_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;
  logic                 rd_stb_q, rd_stb_d;
  logic                 wr_stb_q, wr_stb_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic                 terr_q, terr_d;

  logic [1:0] req;
  logic       pick;
  logic       pick_valid;
  logic       advance;
  logic       sel_write;

  assign req[0]    = req0_read_en | req0_write_en;
  assign req[1]    = req1_read_en | req1_write_en;
  // Write wins when a requester raises both enables.
  assign sel_write = pick ? req1_write_en : req0_write_en;

  dram_port_arbiter_rr_picker u_picker (
    .clk        (clk),
    .reset      (reset),
    .sync_reset (sync_reset),
    .req        (req),
    .advance    (advance),
    .served     (owner_q),
    .pick       (pick),
    .pick_valid (pick_valid)
  );

  // Next-state logic: grant, issue, wait for ack or timeout, then report completion.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    write_d  = write_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    terr_d   = terr_q;
    rd_stb_d = 1'b0;
    wr_stb_d = 1'b0;
    advance  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          owner_d  = pick;
          write_d  = sel_write;
          addr_d   = pick ? req1_addr : req0_addr;
          be_d     = pick ? req1_byte_enable : req0_byte_enable;
          wdata_d  = pick ? req1_write_data : req0_write_data;
          rd_stb_d = ~sel_write;
          wr_stb_d = sel_write;
          rdata_d  = '0;
          cnt_d    = '0;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        // A DRAM that answers in the strobe cycle is taken at once.
        if (dram_ack) begin
          rdata_d = write_q ? '0 : dram_mem_read_data;
          state_d = StDone;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (dram_ack) begin
          rdata_d = write_q ? '0 : dram_mem_read_data;
          state_d = StDone;
        end else if (cnt_q == CNT_LIMIT) begin
          terr_d  = 1'b1;
          rdata_d = write_q ? '0 : TIMEOUT_DATA;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        advance = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; either reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rd_stb_q <= 1'b0;
      wr_stb_q <= 1'b0;
      cnt_q    <= '0;
      terr_q   <= 1'b0;
    end else if (sync_reset) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rd_stb_q <= 1'b0;
      wr_stb_q <= 1'b0;
      cnt_q    <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rd_stb_q <= rd_stb_d;
      wr_stb_q <= wr_stb_d;
      cnt_q    <= cnt_d;
      terr_q   <= terr_d;
    end
  end

  assign req0_ack       = (state_q == StDone) && !owner_q;
  assign req1_ack       = (state_q == StDone) && owner_q;
  assign req0_read_data = req0_ack ? rdata_q : '0;
  assign req1_read_data = req1_ack ? rdata_q : '0;

  assign dram_mem_read_en     = rd_stb_q;
  assign dram_mem_write_en    = wr_stb_q;
  assign dram_mem_addr        = addr_q;
  assign dram_mem_byte_enable = be_q;
  assign dram_mem_write_data  = wdata_q;

  assign grant       = owner_q;
  assign busy        = (state_q != StIdle);
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Scoreboard bench for dram_port_arbiter: requester drivers, a DRAM responder model,
// and a monitor that pops expected strobes/acks as the DUT presents them.
module tb_dram_port_arbiter;

  localparam int TO = 1023;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sync_reset = 1'b0;
  logic        req0_read_en = 1'b0, req0_write_en = 1'b0;
  logic [23:0] req0_addr = '0;
  logic [3:0]  req0_byte_enable = '0;
  logic [31:0] req0_write_data = '0;
  logic        req0_ack;
  logic [31:0] req0_read_data;
  logic        req1_read_en = 1'b0, req1_write_en = 1'b0;
  logic [23:0] req1_addr = '0;
  logic [3:0]  req1_byte_enable = '0;
  logic [31:0] req1_write_data = '0;
  logic        req1_ack;
  logic [31:0] req1_read_data;
  logic        dram_mem_read_en, dram_mem_write_en;
  logic [23:0] dram_mem_addr;
  logic [3:0]  dram_mem_byte_enable;
  logic [31:0] dram_mem_write_data;
  logic        dram_ack = 1'b0;
  logic [31:0] dram_mem_read_data = '0;
  logic        grant, busy, timeout_err;

  dram_port_arbiter #(
    .ADDR_BITS      (24),
    .DATA_BITS      (32),
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_DATA   (32'hDEAD_BEEF)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .sync_reset           (sync_reset),
    .req0_read_en         (req0_read_en),
    .req0_write_en        (req0_write_en),
    .req0_addr            (req0_addr),
    .req0_byte_enable     (req0_byte_enable),
    .req0_write_data      (req0_write_data),
    .req0_ack             (req0_ack),
    .req0_read_data       (req0_read_data),
    .req1_read_en         (req1_read_en),
    .req1_write_en        (req1_write_en),
    .req1_addr            (req1_addr),
    .req1_byte_enable     (req1_byte_enable),
    .req1_write_data      (req1_write_data),
    .req1_ack             (req1_ack),
    .req1_read_data       (req1_read_data),
    .dram_mem_read_en     (dram_mem_read_en),
    .dram_mem_write_en    (dram_mem_write_en),
    .dram_mem_addr        (dram_mem_addr),
    .dram_mem_byte_enable (dram_mem_byte_enable),
    .dram_mem_write_data  (dram_mem_write_data),
    .dram_ack             (dram_ack),
    .dram_mem_read_data   (dram_mem_read_data),
    .grant                (grant),
    .busy                 (busy),
    .timeout_err          (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        wr;
    logic        both;
    logic [23:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } txn_t;

  typedef struct {
    logic        port;
    logic        wr;
    logic [23:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } stb_exp_t;

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          lat;
  } ack_exp_t;

  txn_t     q0[$], q1[$];
  stb_exp_t stb_q[$];
  ack_exp_t ack_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int dram_delay = 4;
  int last_stb = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add_txn(input logic port, input logic wr, input logic both,
                         input logic [23:0] addr, input logic [3:0] be, input logic [31:0] wd);
    txn_t t;
    t.wr = wr; t.both = both; t.addr = addr; t.be = be; t.wd = wd;
    if (port) q1.push_back(t);
    else q0.push_back(t);
  endtask

  task automatic exp_stb(input logic port, input logic wr, input logic [23:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
    stb_exp_t e;
    e.port = port; e.wr = wr; e.addr = addr; e.be = be; e.wd = wd;
    stb_q.push_back(e);
  endtask

  task automatic exp_ack(input logic port, input logic [31:0] data, input int lat);
    ack_exp_t e;
    e.port = port; e.data = data; e.lat = lat;
    ack_q.push_back(e);
  endtask

  // DRAM contents seen by reads: one special word, a pattern elsewhere.
  function automatic logic [31:0] mem_data(input logic [23:0] addr);
    if (addr == 24'h10) return 32'h1234_5678;
    return (32'(addr) * 32'h0101_0101) ^ 32'hA5A5_A5A5;
  endfunction

  // Requester drivers: hold the head transaction until its ack, then present the next.
  always @(negedge clk) begin
    if (req0_ack && q0.size() > 0) void'(q0.pop_front());
    if (req1_ack && q1.size() > 0) void'(q1.pop_front());
    if (q0.size() > 0) begin
      req0_read_en = !q0[0].wr || q0[0].both;  req0_write_en = q0[0].wr;
      req0_addr = q0[0].addr;  req0_byte_enable = q0[0].be;  req0_write_data = q0[0].wd;
    end else begin
      req0_read_en = 1'b0;  req0_write_en = 1'b0;
      req0_addr = '0;  req0_byte_enable = '0;  req0_write_data = '0;
    end
    if (q1.size() > 0) begin
      req1_read_en = !q1[0].wr || q1[0].both;  req1_write_en = q1[0].wr;
      req1_addr = q1[0].addr;  req1_byte_enable = q1[0].be;  req1_write_data = q1[0].wd;
    end else begin
      req1_read_en = 1'b0;  req1_write_en = 1'b0;
      req1_addr = '0;  req1_byte_enable = '0;  req1_write_data = '0;
    end
  end

  // DRAM responder: ack dram_delay cycles after a strobe (0 = same cycle, <0 = never).
  int          dcnt = -1;
  logic [23:0] pend_addr = '0;
  always @(negedge clk) begin
    dram_ack = 1'b0;
    dram_mem_read_data = '0;
    if (dram_mem_read_en || dram_mem_write_en) begin
      pend_addr = dram_mem_addr;
      if (dram_delay == 0) begin
        dram_ack = 1'b1;
        dram_mem_read_data = mem_data(pend_addr);
        dcnt = -1;
      end else begin
        dcnt = dram_delay;
      end
    end else if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) begin
        dram_ack = 1'b1;
        dram_mem_read_data = mem_data(pend_addr);
      end
    end
  end

  // Monitor: every strobe and every ack must match the head of its expectation queue.
  stb_exp_t ms;
  ack_exp_t ma;
  always @(negedge clk) begin
    if (dram_mem_read_en || dram_mem_write_en) begin
      last_stb = cyc;
      chk("strobe_expected", 64'(stb_q.size() > 0), 64'd1);
      if (stb_q.size() > 0) begin
        ms = stb_q.pop_front();
        chk("stb_grant", 64'(grant), 64'(ms.port));
        chk("stb_write_en", 64'(dram_mem_write_en), 64'(ms.wr));
        chk("stb_read_en", 64'(dram_mem_read_en), 64'(!ms.wr));
        chk("stb_addr", 64'(dram_mem_addr), 64'(ms.addr));
        if (ms.wr) begin
          chk("stb_be", 64'(dram_mem_byte_enable), 64'(ms.be));
          chk("stb_wdata", 64'(dram_mem_write_data), 64'(ms.wd));
        end
      end
    end
    if (req0_ack || req1_ack) begin
      chk("single_ack", 64'(req0_ack && req1_ack), 64'd0);
      chk("ack_expected", 64'(ack_q.size() > 0), 64'd1);
      if (ack_q.size() > 0) begin
        ma = ack_q.pop_front();
        chk("ack_port", 64'(req1_ack), 64'(ma.port));
        chk("ack_data", 64'(ma.port ? req1_read_data : req0_read_data), 64'(ma.data));
        chk("ack_latency", 64'(cyc - last_stb), 64'(ma.lat));
      end
    end
    if (!req0_ack) chk("rdata0_idle_zero", 64'(req0_read_data), 64'd0);
    if (!req1_ack) chk("rdata1_idle_zero", 64'(req1_read_data), 64'd0);
  end

  task automatic wait_done(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = (q0.size() == 0) && (q1.size() == 0) && (ack_q.size() == 0) &&
             (stb_q.size() == 0) && !busy;
    end
    chk("drain", 64'(done), 64'd1);
  endtask

  task automatic wait_strobe(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = dram_mem_read_en || dram_mem_write_en;
    end
    chk("strobe_seen", 64'(seen), 64'd1);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_ack0"}, 64'(req0_ack), 64'd0);
    chk({tag, "_ack1"}, 64'(req1_ack), 64'd0);
    chk({tag, "_rd_en"}, 64'(dram_mem_read_en), 64'd0);
    chk({tag, "_wr_en"}, 64'(dram_mem_write_en), 64'd0);
    chk({tag, "_addr"}, 64'(dram_mem_addr), 64'd0);
    chk({tag, "_grant"}, 64'(grant), 64'd0);
    chk({tag, "_terr"}, 64'(timeout_err), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    reset = 1'b0;
    @(negedge clk);

    // 1: port 0 read, DRAM answers 4 cycles after the strobe.
    dram_delay = 4;
    exp_stb(1'b0, 1'b0, 24'h10, 4'h0, 32'h0);
    exp_ack(1'b0, 32'h1234_5678, 5);
    add_txn(1'b0, 1'b0, 1'b0, 24'h10, 4'h0, 32'h0);
    wait_done(100);

    // 2: both ports write together after reset; port 0 first. Port 1 raises both enables.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    exp_stb(1'b0, 1'b1, 24'h40, 4'hF, 32'hCAFE_0001);
    exp_stb(1'b1, 1'b1, 24'h41, 4'h3, 32'hCAFE_0002);
    exp_ack(1'b0, 32'h0, 5);
    exp_ack(1'b1, 32'h0, 5);
    add_txn(1'b0, 1'b1, 1'b0, 24'h40, 4'hF, 32'hCAFE_0001);
    add_txn(1'b1, 1'b1, 1'b1, 24'h41, 4'h3, 32'hCAFE_0002);
    wait_done(100);

    // 3: port 1 streams reads, port 0 joins mid-stream; grants 1,0,1,1.
    dram_delay = 2;
    exp_stb(1'b1, 1'b0, 24'h20, 4'h0, 32'h0);
    exp_stb(1'b0, 1'b0, 24'h30, 4'h0, 32'h0);
    exp_stb(1'b1, 1'b0, 24'h21, 4'h0, 32'h0);
    exp_stb(1'b1, 1'b0, 24'h22, 4'h0, 32'h0);
    exp_ack(1'b1, 32'h8585_8585, 3);
    exp_ack(1'b0, 32'h9595_9595, 3);
    exp_ack(1'b1, 32'h8484_8484, 3);
    exp_ack(1'b1, 32'h8787_8787, 3);
    add_txn(1'b1, 1'b0, 1'b0, 24'h20, 4'h0, 32'h0);
    add_txn(1'b1, 1'b0, 1'b0, 24'h21, 4'h0, 32'h0);
    add_txn(1'b1, 1'b0, 1'b0, 24'h22, 4'h0, 32'h0);
    wait_strobe(20);
    add_txn(1'b0, 1'b0, 1'b0, 24'h30, 4'h0, 32'h0);
    wait_done(100);

    // 4: no DRAM ack -> forced completion with the timeout word, sticky error.
    dram_delay = -1;
    chk("terr_before", 64'(timeout_err), 64'd0);
    exp_stb(1'b0, 1'b0, 24'h50, 4'h0, 32'h0);
    exp_ack(1'b0, 32'hDEAD_BEEF, TO + 2);
    add_txn(1'b0, 1'b0, 1'b0, 24'h50, 4'h0, 32'h0);
    wait_done(TO + 100);
    chk("terr_set", 64'(timeout_err), 64'd1);
    repeat (5) @(negedge clk);
    chk("terr_sticky", 64'(timeout_err), 64'd1);
    sync_reset = 1'b1;
    @(negedge clk);
    sync_reset = 1'b0;
    chk("terr_cleared", 64'(timeout_err), 64'd0);

    // 5: reset during WAIT; the late DRAM ack must be ignored, then a normal request.
    dram_delay = 6;
    exp_stb(1'b0, 1'b0, 24'h60, 4'h0, 32'h0);
    add_txn(1'b0, 1'b0, 1'b0, 24'h60, 4'h0, 32'h0);
    wait_strobe(20);
    repeat (2) @(negedge clk);
    chk("abort_in_wait", 64'(busy), 64'd1);
    reset = 1'b1;
    q0.delete();
    @(negedge clk);
    chk_quiet("abort");
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("late_ack_ignored", 64'(busy), 64'd0);
    dram_delay = 1;
    exp_stb(1'b1, 1'b0, 24'h21, 4'h0, 32'h0);
    exp_ack(1'b1, 32'h8484_8484, 2);
    add_txn(1'b1, 1'b0, 1'b0, 24'h21, 4'h0, 32'h0);
    wait_done(100);

    // 6: DRAM acks in the strobe cycle.
    dram_delay = 0;
    exp_stb(1'b1, 1'b0, 24'h22, 4'h0, 32'h0);
    exp_ack(1'b1, 32'h8787_8787, 1);
    add_txn(1'b1, 1'b0, 1'b0, 24'h22, 4'h0, 32'h0);
    wait_done(100);
    repeat (4) @(negedge clk);
    chk("no_extra_strobe", 64'(stb_q.size()), 64'd0);
    chk("no_pending_ack", 64'(ack_q.size()), 64'd0);
    chk("final_idle", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
